linebuffer_frame_ctrl: RTL and testbench

Frame sequencer for the line-buffer datapath. Accepts a raster pixel stream, enforces a fixed line length and a minimum inter-line gap so the line buffer's address counter restarts on every line, and appends zero flush lines after the last image row so bottom-row windows are produced. Sits between the video source and the line-buffer core. Tags the operator data returned by the core with a window-valid strobe and centre-row/column coordinates.

---
 rtl/linebuffer_frame_ctrl.sv | 176 +++++++++++++++++
 tb/tb_linebuffer_frame_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/linebuffer_frame_ctrl.sv
// Frame sequencer in front of the line-buffer core: enforces fixed line length and inter-line gaps,
// appends zero flush lines, and tags the core's operator output with window-valid and coordinates.
`timescale 1ns/1ps

module linebuffer_frame_ctrl #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 11,
    parameter int OPERATOR_HEIGHT = 3,
    parameter int IMG_WIDTH       = 640,
    parameter int IMG_HEIGHT      = 480,
    parameter int MIN_GAP         = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  FrameStart,
    input  logic                  InEn,
    input  logic [DATA_WIDTH-1:0] InData,
    output logic                  InReady,
    output logic                  LbDataEn,
    output logic [DATA_WIDTH-1:0] LbPixelData,
    input  logic                  LbOperatorDataEn,
    output logic                  WinEn,
    output logic [ADDR_WIDTH-1:0] WinRow,
    output logic [ADDR_WIDTH-1:0] WinCol,
    output logic                  Busy,
    output logic                  FrameDone,
    output logic                  LineLenErr,
    output logic                  SyncErr
);

    localparam int F      = (OPERATOR_HEIGHT - 1) / 2;
    localparam int ROW_W  = $clog2(IMG_HEIGHT + 1);
    localparam int FLSH_W = $clog2(F + 1);
    localparam int GAP_W  = $clog2(MIN_GAP);

    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]      ROWS     = ROW_W'(IMG_HEIGHT);
    localparam logic [FLSH_W-1:0]     FLUSHES  = FLSH_W'(F);
    localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'(MIN_GAP - 1);
    localparam logic [ADDR_WIDTH-1:0] WIN_ROW0 = ADDR_WIDTH'(OPERATOR_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_LINE, S_LINE, S_PAD, S_GAP, S_FLUSH, S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_col;
    logic [ROW_W-1:0]        r_in_row;
    logic [FLSH_W-1:0]       r_flush_cnt;
    logic [GAP_W-1:0]        r_gap_cnt;
    logic [ADDR_WIDTH-1:0]   r_out_row;
    logic [ADDR_WIDTH-1:0]   r_out_col;
    logic                    r_op_en_d;
    logic                    r_lb_en;
    logic [DATA_WIDTH-1:0]   r_lb_data;
    logic                    r_len_err;
    logic                    r_sync_err;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_emit;
    logic [DATA_WIDTH-1:0]   w_pix;
    logic                    w_line_end;
    logic                    w_flush_end;
    logic                    w_short;
    logic                    w_busy;
    logic                    w_done;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (FrameStart) w_next = S_WAIT_LINE;
            S_WAIT_LINE: if (InEn) w_next = (IMG_WIDTH == 1) ? S_GAP : S_LINE;
            S_LINE: begin
                if (r_col == LAST_COL) w_next = S_GAP;
                else if (!InEn)        w_next = S_PAD;
            end
            S_PAD:       if (r_col == LAST_COL) w_next = S_GAP;
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    if (r_in_row != ROWS)           w_next = S_WAIT_LINE;
                    else if (r_flush_cnt != FLUSHES) w_next = S_FLUSH;
                    else                            w_next = S_DONE;
                end
            end
            S_FLUSH:     if (r_col == LAST_COL) w_next = S_GAP;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Output / control decode. A short line starts padding in the same cycle InEn drops,
    // so LbDataEn stays contiguous for the whole line and the core sees one unbroken run.
    always_comb begin
        w_in_ready  = (r_state == S_WAIT_LINE) || (r_state == S_LINE);
        w_accept    = w_in_ready && InEn;
        w_short     = (r_state == S_LINE) && !InEn;
        w_emit      = w_accept || w_short || (r_state == S_PAD) || (r_state == S_FLUSH);
        w_pix       = w_accept ? InData : '0;
        w_line_end  = ((r_state == S_WAIT_LINE) && InEn && (IMG_WIDTH == 1))
                   || (((r_state == S_LINE) || (r_state == S_PAD)) && (r_col == LAST_COL));
        w_flush_end = (r_state == S_FLUSH) && (r_col == LAST_COL);
        w_busy      = (r_state != S_IDLE);
        w_done      = (r_state == S_DONE);
    end

    // Input-side counters and registered line-buffer drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col       <= '0;
            r_in_row    <= '0;
            r_flush_cnt <= '0;
            r_gap_cnt   <= '0;
            r_lb_en     <= 1'b0;
            r_lb_data   <= '0;
            r_len_err   <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_lb_en    <= w_emit;
            r_lb_data  <= w_pix;
            r_len_err  <= w_short;
            r_sync_err <= FrameStart && (r_state != S_IDLE);
            r_gap_cnt  <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;

            if ((r_state == S_IDLE) || (r_state == S_GAP)) r_col <= '0;
            else if (w_emit)                                r_col <= r_col + 1'b1;

            if (r_state == S_IDLE)  r_in_row <= '0;
            else if (w_line_end)    r_in_row <= r_in_row + 1'b1;

            if (r_state == S_IDLE)  r_flush_cnt <= '0;
            else if (w_flush_end)   r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    // Output-side tagging: a falling edge of the core's enable closes one output line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_en_d <= 1'b0;
            r_out_row <= '0;
            r_out_col <= '0;
        end else begin
            r_op_en_d <= LbOperatorDataEn;
            if (r_state == S_IDLE) begin
                r_out_row <= '0;
                r_out_col <= '0;
            end else if (LbOperatorDataEn) begin
                r_out_col <= r_out_col + 1'b1;
            end else if (r_op_en_d) begin
                r_out_col <= '0;
                r_out_row <= r_out_row + 1'b1;
            end
        end
    end

    assign InReady     = w_in_ready;
    assign LbDataEn    = r_lb_en;
    assign LbPixelData = r_lb_data;
    assign Busy        = w_busy;
    assign FrameDone   = w_done;
    assign LineLenErr  = r_len_err;
    assign SyncErr     = r_sync_err;
    // Rows above the first full window hold stale or partial data and are masked here
    assign WinEn       = LbOperatorDataEn && (r_out_row >= WIN_ROW0);
    assign WinRow      = r_out_row - ADDR_WIDTH'(F);
    assign WinCol      = r_out_col;

endmodule

// File: tb/tb_linebuffer_frame_ctrl.sv
// Randomized frame-level bench for linebuffer_frame_ctrl: frame-image model with an expected pixel
// queue and an expected window-coordinate queue; the line-buffer core is modelled as a 2-cycle enable delay.
`timescale 1ns/1ps

module tb_linebuffer_frame_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 11;
    localparam int N     = 3;
    localparam int W     = 8;
    localparam int H     = 4;
    localparam int MG    = 3;
    localparam int F     = (N - 1) / 2;
    localparam int LINES = H + F;

    logic          clk = 1'b0;
    logic          rst;
    logic          FrameStart;
    logic          InEn;
    logic [DW-1:0] InData;
    logic          InReady;
    logic          LbDataEn;
    logic [DW-1:0] LbPixelData;
    logic          LbOperatorDataEn;
    logic          WinEn;
    logic [AW-1:0] WinRow;
    logic [AW-1:0] WinCol;
    logic          Busy;
    logic          FrameDone;
    logic          LineLenErr;
    logic          SyncErr;
    logic          op_d1;
    logic          op_d2;

    linebuffer_frame_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPERATOR_HEIGHT(N),
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .MIN_GAP(MG)
    ) dut (
        .clk(clk), .rst(rst), .FrameStart(FrameStart), .InEn(InEn), .InData(InData),
        .InReady(InReady), .LbDataEn(LbDataEn), .LbPixelData(LbPixelData),
        .LbOperatorDataEn(LbOperatorDataEn), .WinEn(WinEn), .WinRow(WinRow), .WinCol(WinCol),
        .Busy(Busy), .FrameDone(FrameDone), .LineLenErr(LineLenErr), .SyncErr(SyncErr)
    );

    // Clock / reset and line-buffer core latency model
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            op_d1 <= 1'b0;
            op_d2 <= 1'b0;
        end else begin
            op_d1 <= LbDataEn;
            op_d2 <= op_d1;
        end
    end
    assign LbOperatorDataEn = op_d2;

    // Scoreboard state
    int            total = 0;
    int            bad   = 0;
    int            img [LINES][W];
    int            hist[LINES][W];
    logic [DW-1:0] exp_q[$];
    int            win_q[$];
    int            done_cnt = 0;
    int            len_cnt  = 0;
    int            sync_cnt = 0;
    int            mon_line = 0;
    int            mon_col  = 0;
    int            low_run  = MG;
    logic [DW-1:0] pd1 = '0;
    logic [DW-1:0] pd2 = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic monitor();
        int w, r, c;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_line = 0; mon_col = 0; low_run = MG; pd1 = '0; pd2 = '0;
                continue;
            end
            if (WinEn) begin
                if (win_q.size() == 0) check("win_extra", 1, 0);
                else begin
                    w = win_q.pop_front();
                    r = w / 256;
                    c = w % 256;
                    check("win_row", 32'(WinRow), r);
                    check("win_col", 32'(WinCol), c);
                    check("win_newest_pix", 32'(pd2), img[r+F][c]);
                    check("win_centre_pix", hist[r][c], img[r][c]);
                end
            end
            if (LbDataEn) begin
                if (mon_col == 0 && mon_line > 0) check("gap_len_ok", 32'(low_run >= MG), 1);
                low_run = 0;
                if (exp_q.size() == 0) check("pix_extra", 1, 0);
                else check("pix", 32'(LbPixelData), 32'(exp_q.pop_front()));
                if (mon_line < LINES) hist[mon_line][mon_col] = int'(LbPixelData);
                mon_col++;
                if (mon_col == W) begin
                    mon_col = 0;
                    mon_line++;
                end
            end else begin
                low_run++;
            end
            if (LineLenErr) len_cnt++;
            if (SyncErr)    sync_cnt++;
            if (FrameDone) begin
                done_cnt++;
                check("lines_per_frame", mon_line, LINES);
                check("line_complete", mon_col, 0);
                mon_line = 0;
                mon_col  = 0;
            end
            pd2 = pd1;
            pd1 = LbPixelData;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_inready"}, 32'(InReady), 0);
        check({tag, "_lbdataen"}, 32'(LbDataEn), 0);
        check({tag, "_lbpix"}, 32'(LbPixelData), 0);
        check({tag, "_busy"}, 32'(Busy), 0);
        check({tag, "_framedone"}, 32'(FrameDone), 0);
        check({tag, "_linelenerr"}, 32'(LineLenErr), 0);
        check({tag, "_syncerr"}, 32'(SyncErr), 0);
        check({tag, "_winen"}, 32'(WinEn), 0);
    endtask

    // Driver: builds the expected frame, then streams it; short_row/sync_row/abort_row < 0 disable
    task automatic run_frame(input bit rnd, input bit hold, input int short_row, input int short_len,
                             input int sync_row, input int abort_row);
        int  d0, l0, s0, idle, stall;
        bit  acc, got, prev_short;
        for (int r = 0; r < LINES; r++)
            for (int c = 0; c < W; c++) begin
                if (r >= H)                              img[r][c] = 0;
                else if (r == short_row && c >= short_len) img[r][c] = 0;
                else if (rnd)                            img[r][c] = int'($urandom_range(0, 255));
                else                                     img[r][c] = r * 16 + c;
                exp_q.push_back(DW'(img[r][c]));
            end
        for (int r = F; r < H; r++)
            for (int c = 0; c < W; c++) win_q.push_back(r * 256 + c);
        d0 = done_cnt; l0 = len_cnt; s0 = sync_cnt;

        @(posedge clk); #1 FrameStart = 1'b1;
        @(posedge clk); #1 FrameStart = 1'b0;
        prev_short = 1'b1;
        for (int r = 0; r < H; r++) begin
            idle = hold ? 0 : int'($urandom_range(0, 2));
            if (r == sync_row && idle == 0) idle = 1;
            for (int k = 0; k < idle; k++) begin
                InEn       = 1'b0;
                FrameStart = (r == sync_row) && (k == 0);
                @(posedge clk); #1;
            end
            FrameStart = 1'b0;
            for (int c = 0; c < W; c++) begin
                if (r == short_row && c == short_len) break;
                if (r == abort_row && c == 3) return;
                InEn   = 1'b1;
                InData = DW'(img[r][c]);
                acc    = 1'b0;
                stall  = 0;
                while (!acc && stall < 200) begin
                    @(negedge clk);
                    if (InReady) acc = 1'b1;
                    else stall++;
                    @(posedge clk); #1;
                end
                if (!acc) check("accept_timeout", 0, 1);
                if (c == 0 && idle == 0 && !prev_short) check("gap_stall", stall, MG);
                if (c > 0) check("line_stall", stall, 0);
            end
            if (r == short_row) begin
                InEn = 1'b0;
                @(posedge clk); #1;
            end
            prev_short = (r == short_row);
        end
        InEn = 1'b0;

        got = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (FrameDone) begin
                got = 1'b1;
                check("busy_at_done", 32'(Busy), 1);
                break;
            end
        end
        check("frame_done_seen", 32'(got), 1);
        @(negedge clk);
        check("busy_after_done", 32'(Busy), 0);
        check("done_one_pulse", 32'(FrameDone), 0);
        check("done_count", done_cnt - d0, 1);
        check("len_err_count", len_cnt - l0, (short_row >= 0 && short_row < H) ? 1 : 0);
        check("sync_err_count", sync_cnt - s0, (sync_row >= 0) ? 1 : 0);
        check("pix_left", exp_q.size(), 0);
        check("win_left", win_q.size(), 0);
    endtask

    initial begin
        int sr;
        rst = 1'b1; FrameStart = 1'b0; InEn = 1'b0; InData = '0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1 check_all_zero("idle");

        run_frame(1'b0, 1'b0, -1, 0, -1, -1);   // full frame, row*16+col pixels
        run_frame(1'b0, 1'b0,  1, 5, -1, -1);   // line 2 cut after 5 pixels
        run_frame(1'b0, 1'b1, -1, 0, -1, -1);   // InEn held through every gap
        run_frame(1'b0, 1'b0, -1, 0,  2, -1);   // stray FrameStart mid-frame

        // Reset in the middle of line 3
        run_frame(1'b0, 1'b1, -1, 0, -1, 2);
        #3 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        @(posedge clk); #1;
        rst  = 1'b0;
        InEn = 1'b0;
        exp_q.delete();
        win_q.delete();
        @(posedge clk); #1 check_all_zero("post_rst");
        run_frame(1'b0, 1'b0, -1, 0, -1, -1);

        for (int i = 0; i < 4; i++) begin
            sr = int'($urandom_range(0, H));
            run_frame(1'b1, 1'($urandom_range(0, 1)), (sr == H) ? -1 : sr,
                      int'($urandom_range(1, W - 1)), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
